// File: rtl/spi_sclk_gen_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg : shared FSM encoding, SPI mode constants, default widths. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package spi_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen_if.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen_if : request/config and SCK/strobe bundle of the SCK generator. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface spi_sclk_gen_if
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             start;
  logic             abort;
  logic [DIV_W-1:0] half_div;
  logic             cpol;
  logic             cpha;
  logic [CNT_W-1:0] n_bits;
  logic             sclk;
  logic             busy;
  logic             done;
  logic             shift_stb;
  logic             sample_stb;
  logic [CNT_W-1:0] bit_idx;

  modport master (
    output start, abort, half_div, cpol, cpha, n_bits,
    input  sclk, busy, done, shift_stb, sample_stb, bit_idx
  );

  modport slave (
    input  start, abort, half_div, cpol, cpha, n_bits,
    output sclk, busy, done, shift_stb, sample_stb, bit_idx
  );

endinterface

`default_nettype wire

// File: rtl/spi_sclk_gen_half_period_cnt.sv
// -----------------------------------------------------------------------------
// spi_half_period_cnt : loadable half-period counter, wraps after limit counts. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module spi_half_period_cnt
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  wire logic             clk_50,
  input  wire logic             rst_n,
  input  wire logic             clr_i,
  input  wire logic             en_i,
  input  wire logic [DIV_W-1:0] limit_i,
  output logic                  wrap_o
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  // >= rather than == so a stale count can never run past the limit
  assign wrap_o = en_i && (count_q >= (limit_i - DIV_W'(1)));

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = wrap_o ? '0 : count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen : SPI SCK generator, all CPOL/CPHA modes, shift/sample strobes. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input wire logic     clk_50,
  input wire logic     rst_n,
  spi_sclk_gen_if.slave bus
);

  localparam int K_W = CNT_W + 1;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] h_q, h_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;

  logic             w_busy, w_accept, w_abort, w_wrap, w_edge;
  logic             w_cnt_en, w_cnt_clr, w_cpol_e, w_cpha_e;
  logic [DIV_W-1:0] w_h_in, w_limit;
  logic [CNT_W-1:0] w_n_e;
  logic [K_W-1:0]   w_k, w_last_k;

  assign w_busy   = (state_q != ST_IDLE);
  assign w_accept = bus.start && !w_busy;
  assign w_abort  = bus.abort && w_busy;
  assign w_h_in   = (bus.half_div == '0) ? DIV_W'(1) : bus.half_div;

  // The accept cycle already counts toward the first half period, so the
  // edge logic uses the live inputs there and the latched copies afterwards.
  assign w_limit  = w_accept ? w_h_in     : h_q;
  assign w_n_e    = w_accept ? bus.n_bits : n_q;
  assign w_cpol_e = w_accept ? bus.cpol   : cpol_q;
  assign w_cpha_e = w_accept ? bus.cpha   : cpha_q;
  assign w_k      = w_accept ? '0         : k_q;
  assign w_last_k = {w_n_e, 1'b0} - K_W'(1);

  assign w_cnt_en  = (w_accept && (bus.n_bits != '0)) || (w_busy && !w_abort);
  assign w_cnt_clr = !w_cnt_en;
  assign w_edge    = w_wrap && (state_q != ST_TAIL) && !w_abort;

  spi_half_period_cnt #(
    .DIV_W (DIV_W)
  ) u_half_cnt (
    .clk_50  (clk_50),
    .rst_n   (rst_n),
    .clr_i   (w_cnt_clr),
    .en_i    (w_cnt_en),
    .limit_i (w_limit),
    .wrap_o  (w_wrap)
  );

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    n_d       = n_q;
    k_d       = k_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;
    shift_d   = 1'b0;
    sample_d  = 1'b0;
    bit_idx_d = bit_idx_q + {{(CNT_W-1){1'b0}}, sample_q};

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = bus.cpol;
        if (w_accept) begin
          h_d       = w_h_in;
          cpol_d    = bus.cpol;
          cpha_d    = bus.cpha;
          n_d       = bus.n_bits;
          k_d       = '0;
          bit_idx_d = '0;
          if (bus.n_bits == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
        end
      end
      ST_TAIL: begin
        if (w_abort) begin
          state_d = ST_IDLE;
          sclk_d  = cpol_q;
        end else if (w_wrap) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Even k is the leading edge (away from idle), odd k the trailing edge.
    if (w_edge) begin
      sclk_d = w_k[0] ? w_cpol_e : ~w_cpol_e;
      if (w_k[0]) begin
        sample_d = w_cpha_e;
        shift_d  = !w_cpha_e && (w_k != w_last_k);
      end else begin
        sample_d = !w_cpha_e;
        shift_d  = w_cpha_e;
      end
      if (w_k == w_last_k) begin
        state_d = ST_TAIL;
      end else begin
        k_d = w_k + K_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      h_q       <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      n_q       <= '0;
      k_q       <= '0;
      bit_idx_q <= '0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      n_q       <= n_d;
      k_q       <= k_d;
      bit_idx_q <= bit_idx_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
    end
  end

  assign bus.sclk       = sclk_q;
  assign bus.busy       = w_busy;
  assign bus.done       = done_q;
  assign bus.shift_stb  = shift_q;
  assign bus.sample_stb = sample_q;
  assign bus.bit_idx    = bit_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_sclk_gen : scoreboard bench for spi_sclk_gen. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_spi_sclk_gen;
  import spi_pkg::*;

  localparam int DW = 16;
  localparam int CW = 6;

  logic clk_50 = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   failures = 0;

  spi_sclk_gen_if #(.DIV_W(DW), .CNT_W(CW)) bus ();

  spi_sclk_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit shift;
    bit sample;
    bit done;
    bit sclk;
    int bidx;
  } ev_t;

  ev_t q[$];
  ev_t me;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Expected strobe/done events for one accepted burst, from the edge timing rules.
  function automatic void push_burst(int t0, int h, int n, bit pol, bit pha);
    int  he = (h == 0) ? 1 : h;
    int  samples = 0;
    ev_t e;
    for (int k = 0; k < 2 * n; k++) begin
      bit lead;
      lead     = (k % 2 == 0);
      e.cyc    = t0 + (k + 1) * he;
      e.sclk   = lead ? ~pol : pol;
      e.done   = 1'b0;
      e.sample = pha ? !lead : lead;
      e.shift  = pha ? lead : (!lead && (k != 2 * n - 1));
      e.bidx   = samples;
      if (e.sample) samples++;
      if (e.shift || e.sample) q.push_back(e);
    end
    e.cyc    = (n == 0) ? t0 + 1 : t0 + (2 * n + 1) * he;
    e.sclk   = pol;
    e.shift  = 1'b0;
    e.sample = 1'b0;
    e.done   = 1'b1;
    e.bidx   = n;
    q.push_back(e);
  endfunction

  function automatic void flush_after(int c);
    ev_t t;
    while (q.size() > 0) begin
      t = q[q.size() - 1];
      if (t.cyc <= c) break;
      void'(q.pop_back());
    end
  endfunction

  always @(negedge clk_50) begin
    if ((bus.shift_stb === 1'b1) || (bus.sample_stb === 1'b1) || (bus.done === 1'b1)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_event: cycle %0d shift=%b sample=%b done=%b, expected no event",
                 cyc, bus.shift_stb, bus.sample_stb, bus.done);
      end else begin
        me = q.pop_front();
        chk("ev_cycle",  cyc,            me.cyc);
        chk("ev_shift",  bus.shift_stb,  me.shift);
        chk("ev_sample", bus.sample_stb, me.sample);
        chk("ev_done",   bus.done,       me.done);
        chk("ev_sclk",   bus.sclk,       me.sclk);
        chk("ev_bitidx", bus.bit_idx,    me.bidx);
      end
    end
  end

  task automatic tick();
    @(negedge clk_50);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic burst(input int h, input int n, input logic [1:0] mode, output int t0);
    bus.half_div = DW'(h);
    bus.n_bits   = CW'(n);
    bus.cpol     = mode[1];
    bus.cpha     = mode[0];
    bus.start    = 1'b1;
    t0 = cyc;
    push_burst(t0, h, n, mode[1], mode[0]);
    chk("busy_at_accept", bus.busy, 0);
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d, simulation did not finish", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    bus.start = 0; bus.abort = 0; bus.half_div = 2;
    bus.cpol = 0; bus.cpha = 0; bus.n_bits = 8;
    repeat (3) tick();
    chk("rst_sclk", bus.sclk, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_shift", bus.shift_stb, 0);
    chk("rst_sample", bus.sample_stb, 0);
    chk("rst_bitidx", bus.bit_idx, 0);
    rst_n = 1'b1;
    tick();
    bus.cpol = 1'b1; tick();
    chk("idle_follow_cpol1", bus.sclk, 1);
    bus.cpol = 1'b0; tick();
    chk("idle_follow_cpol0", bus.sclk, 0);

    // Mode0, H=2, N=8
    burst(2, 8, MODE0, t0);
    chk("m0_busy_t1", bus.busy, 1);
    wait_to(t0 + 31); chk("m0_sclk_t31", bus.sclk, 1);
    wait_to(t0 + 32); chk("m0_sclk_last_fall", bus.sclk, 0);
    wait_to(t0 + 33); chk("m0_busy_t33", bus.busy, 1);
    wait_to(t0 + 34); chk("m0_busy_done", bus.busy, 0);
    wait_to(t0 + 36); chk("m0_sb_drained", q.size(), 0);

    // Mode3, H=1, N=4
    bus.cpol = 1'b1; tick(); tick();
    chk("m3_idle_high", bus.sclk, 1);
    burst(1, 4, MODE3, t0);
    chk("m3_first_fall", bus.sclk, 0);
    wait_to(t0 + 11); chk("m3_sb_drained", q.size(), 0);

    // H=0 behaves as H=1; N=0 completes without busy
    bus.cpol = 1'b0; tick(); tick();
    burst(0, 2, MODE0, t0);
    wait_to(t0 + 7); chk("h0_sb_drained", q.size(), 0);
    burst(1, 2, MODE0, t0);
    wait_to(t0 + 7); chk("h1_sb_drained", q.size(), 0);
    burst(3, 0, MODE0, t0);
    chk("n0_busy_t1", bus.busy, 0);
    chk("n0_sclk_t1", bus.sclk, 0);
    tick();
    chk("n0_busy_t2", bus.busy, 0);
    chk("n0_sb_drained", q.size(), 0);

    // Abort at T0+5 suppresses the coincident edge and everything after
    burst(2, 8, MODE0, t0);
    wait_to(t0 + 5);
    bus.abort = 1'b1;
    flush_after(t0 + 5);
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_sclk", bus.sclk, 0);
    tick();
    burst(2, 8, MODE0, t0);
    wait_to(t0 + 36); chk("abort_rerun_drained", q.size(), 0);

    // Reset mid-burst, then repeated starts during a burst
    burst(2, 4, MODE2, t0);
    wait_to(t0 + 7);
    rst_n = 1'b0;
    flush_after(t0 + 7);
    tick();
    chk("midrst_sclk", bus.sclk, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_bitidx", bus.bit_idx, 0);
    rst_n = 1'b1;
    bus.cpol = 1'b0; tick(); tick();
    burst(2, 4, MODE1, t0);
    bus.start = 1'b1;
    repeat (9) tick();
    bus.start = 1'b0;
    wait_to(t0 + 21); chk("multistart_drained", q.size(), 0);

    // Back-to-back: start held across done, cpol changed mid-burst
    burst(1, 3, MODE0, t0);
    bus.start = 1'b1;
    bus.cpol  = 1'b1;
    wait_to(t0 + 7);
    push_burst(t0 + 7, 1, 3, 1'b1, 1'b0);
    chk("b2b_idle_at_done", bus.busy, 0);
    tick();
    bus.start = 1'b0;
    chk("b2b_busy_second", bus.busy, 1);
    chk("b2b_bitidx_clr", bus.bit_idx, 0);
    wait_to(t0 + 16); chk("b2b_sb_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
